// File: rtl/fpga_ccff_loader.sv
// fpga_ccff_loader: Wishbone slave that streams FIFO-buffered 32-bit words
// MSB-first into the FPGA configuration chain and captures the chain tail.
module fpga_ccff_loader #(
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        prog_clk_o,
   output logic        prog_reset_o,
   output logic        ccff_head_o,
   input  logic        ccff_tail_i,
   output logic        busy_o,
   output logic        irq_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, LOW, HIGH} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [4:0]    bitcnt_q, bitcnt_d;
   logic [31:0]   shreg_q, shreg_d;
   logic [31:0]   rb_q, rb_d;
   logic          head_q, head_d;
   logic          pclk_q, pclk_d;
   logic          busy_q, busy_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          prog_reset_q, prog_reset_d;
   logic          irq_en_q, irq_en_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          irq_q, irq_d;
   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;

   logic        req, wr, rd;
   logic        wr_ctrl, wr_stat, wr_data;
   logic        abort, full, empty;
   logic        push, pop, last_div, done_set;
   logic [31:0] status;
   logic        unused;

   assign unused = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

   assign req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign wr      = req & wbs_we_i;
   assign rd      = req & ~wbs_we_i;
   assign wr_ctrl = wr & (wbs_adr_i[3:2] == 2'd0);
   assign wr_stat = wr & (wbs_adr_i[3:2] == 2'd1);
   assign wr_data = wr & (wbs_adr_i[3:2] == 2'd2);

   assign full     = (level_q == (AW+1)'(FIFO_DEPTH));
   assign empty    = (level_q == '0);
   assign last_div = (div_q == DW'(CLK_DIV - 1));

   // Abort or re-asserting prog_reset kills an in-flight word.
   assign abort = wr_ctrl & (wbs_dat_i[2] | wbs_dat_i[0])
                & (state_q != IDLE);
   assign pop   = (state_q == LOAD) & ~abort;
   assign push  = wr_data & (~full | pop);

   assign status = {21'b0, 3'(level_q), 3'b0,
                    ovf_q, done_q, empty, full, busy_q};

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      rb_d     = rb_q;
      done_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && !prog_reset_q) state_d = LOAD;
         end
         LOAD: begin
            shreg_d  = mem_q[rd_ptr_q];
            bitcnt_d = '0;
            div_d    = '0;
            state_d  = LOW;
         end
         LOW: begin
            div_d = div_q + 1'b1;
            if (last_div) begin
               div_d   = '0;
               rb_d    = {rb_q[30:0], ccff_tail_i};
               state_d = HIGH;
            end
         end
         HIGH: begin
            div_d = div_q + 1'b1;
            if (last_div) begin
               div_d    = '0;
               shreg_d  = {shreg_q[30:0], 1'b0};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q != 5'd31) begin
                  state_d = LOW;
               end else if (!empty) begin
                  state_d = LOAD;
               end else begin
                  state_d  = IDLE;
                  done_set = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d  = IDLE;
         div_d    = '0;
         done_set = 1'b0;
      end
      head_d = (state_d == LOW) ? shreg_d[31] : head_q;
      pclk_d = (state_d == HIGH);
      busy_d = (state_d != IDLE);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_comb begin
      prog_reset_d = prog_reset_q;
      irq_en_d     = irq_en_q;
      done_d       = done_q;
      ovf_d        = ovf_q;
      if (wr_ctrl) begin
         prog_reset_d = wbs_dat_i[0];
         irq_en_d     = wbs_dat_i[1];
      end
      if (wr_stat && wbs_dat_i[3]) done_d = 1'b0;
      if (wr_stat && wbs_dat_i[4]) ovf_d  = 1'b0;
      if (done_set) done_d = 1'b1;
      if (wr_data && full && !pop) ovf_d = 1'b1;
      irq_d = done_q & irq_en_q;
      ack_d = req;
      dat_d = '0;
      if (rd) begin
         case (wbs_adr_i[3:2])
            2'd0:    dat_d = {30'b0, irq_en_q, prog_reset_q};
            2'd1:    dat_d = status;
            2'd3:    dat_d = rb_q;
            default: dat_d = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wbs_dat_i;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= IDLE;
         div_q        <= '0;
         bitcnt_q     <= '0;
         shreg_q      <= '0;
         rb_q         <= '0;
         head_q       <= 1'b0;
         pclk_q       <= 1'b0;
         busy_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         prog_reset_q <= 1'b1;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         irq_q        <= 1'b0;
         ack_q        <= 1'b0;
         dat_q        <= '0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         bitcnt_q     <= bitcnt_d;
         shreg_q      <= shreg_d;
         rb_q         <= rb_d;
         head_q       <= head_d;
         pclk_q       <= pclk_d;
         busy_q       <= busy_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         prog_reset_q <= prog_reset_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
         irq_q        <= irq_d;
         ack_q        <= ack_d;
         dat_q        <= dat_d;
      end
   end

   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = dat_q;
   assign prog_clk_o   = pclk_q;
   assign prog_reset_o = prog_reset_q;
   assign ccff_head_o  = head_q;
   assign busy_o       = busy_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_fpga_ccff_loader.sv
// Scoreboard bench for fpga_ccff_loader: Wishbone reads and chain head bits
// are predicted up front and checked by an independent monitor.
module tb_fpga_ccff_loader;

   logic        clk;
   logic        rst;
   logic        stb, cyc, we_i;
   logic [3:0]  sel;
   logic [31:0] dat_i, adr;
   logic        ack;
   logic [31:0] dat_o;
   logic        pclk, preset, head, tail, busy, irq;

   logic [31:0] chain;
   assign tail = chain[31];

   int checks = 0;
   int errors = 0;
   int edges  = 0;

   logic [31:0] exp_q [$];
   string       name_q [$];
   logic        bit_q [$];

   fpga_ccff_loader #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we_i),
      .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
      .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .prog_clk_o(pclk), .prog_reset_o(preset),
      .ccff_head_o(head), .ccff_tail_i(tail),
      .busy_o(busy), .irq_o(irq)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: pops predicted read data and head bits as the DUT presents them.
   logic pclk_prev = 1'b0;
   logic ack_prev  = 1'b0;
   always @(negedge clk) begin
      if (ack) begin
         checks++;
         if (ack_prev) begin
            errors++;
            $display("FAIL ack_width: got 2+ cycles expected 1");
         end
      end
      if (ack && !we_i) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: got 0x%08h expected none", dat_o);
         end else begin
            chk(name_q.pop_front(), dat_o, exp_q.pop_front());
         end
      end
      if (pclk && !pclk_prev) begin
         edges++;
         if (bit_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_edge: got edge %0d expected none", edges);
         end else begin
            chk("head_bit", 32'(head), 32'(bit_q.pop_front()));
         end
         chain = {chain[30:0], head};
      end
      pclk_prev = pclk;
      ack_prev  = ack;
   end

   task automatic wb_xfer(input logic w, input logic [1:0] a,
                          input logic [31:0] d);
      int n;
      @(negedge clk);
      stb = 1; cyc = 1; we_i = w;
      adr = {28'h0, a, 2'b00}; dat_i = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 8);
      if (!ack) begin
         checks++; errors++;
         $display("FAIL ack_timeout: got no ack expected ack for adr %0d", a);
      end
      @(posedge clk); #1;
      stb = 0; cyc = 0; we_i = 0;
   endtask

   task automatic wb_read(input logic [1:0] a, input logic [31:0] e,
                          input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      wb_xfer(1'b0, a, 32'h0);
   endtask

   task automatic push_word(input logic [31:0] w, input bit accept);
      if (accept)
         for (int i = 31; i >= 0; i--) bit_q.push_back(w[i]);
      wb_xfer(1'b1, 2'd2, w);
   endtask

   task automatic wait_done(input int budget, output int bcyc);
      int  n;
      bit  seen;
      bcyc = 0;
      seen = 0;
      for (n = 0; n < budget; n++) begin
         @(negedge clk);
         if (busy) begin
            seen = 1;
            bcyc++;
         end else if (seen) begin
            break;
         end
      end
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL busy_timeout: got busy=%0d expected idle", busy);
      end
   endtask

   function automatic logic [31:0] st(int lvl, bit ovf, bit dn, bit bsy);
      int v;
      v = lvl * 256 + ovf * 16 + dn * 8 + (lvl == 0) * 4
        + (lvl == 4) * 2 + bsy;
      return 32'(v);
   endfunction

   initial begin
      logic [31:0] words [$];
      logic [31:0] w;
      int bcyc, e0, lvl, n;
      bit ovf, acc;

      rst = 1; stb = 0; cyc = 0; we_i = 0;
      sel = 4'hF; dat_i = 0; adr = 0; chain = 0;
      repeat (2) @(negedge clk);
      chk("rst_prog_clk", 32'(pclk), 0);
      chk("rst_prog_reset", 32'(preset), 1);
      chk("rst_head", 32'(head), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_dat_o", dat_o, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_irq", 32'(irq), 0);
      rst = 0;
      wb_read(2'd1, 32'h0000_0004, "rst_status");
      wb_read(2'd0, 32'h0000_0001, "rst_ctrl");
      wb_read(2'd3, 32'h0, "rst_readback");

      // Single word, chain preloaded for readback
      chain = 32'h1234_5678;
      wb_xfer(1'b1, 2'd0, 32'h0);
      e0 = edges;
      push_word(32'hA500_0001, 1);
      wait_done(400, bcyc);
      chk("single_busy_cycles", bcyc, 129);
      chk("single_edges", edges - e0, 32);
      chk("single_chain", chain, 32'hA500_0001);
      chk("single_irq_off", 32'(irq), 0);
      wb_read(2'd1, st(0, 0, 1, 0), "single_status");
      wb_read(2'd3, 32'h1234_5678, "single_readback");
      wb_read(2'd2, 32'h0, "data_reads_zero");
      wb_xfer(1'b1, 2'd1, 32'h8);
      wb_read(2'd1, st(0, 0, 0, 0), "done_cleared");

      // FIFO depth and overflow with random words
      wb_xfer(1'b1, 2'd0, 32'h1);
      lvl = 0; ovf = 0;
      for (int i = 0; i < 5; i++) begin
         w = $urandom;
         acc = (lvl < 4);
         if (acc) begin
            lvl++;
            words.push_back(w);
         end else begin
            ovf = 1;
         end
         push_word(w, acc);
      end
      wb_read(2'd1, st(lvl, ovf, 0, 0), "ovf_status");
      e0 = edges;
      wb_xfer(1'b1, 2'd0, 32'h0);
      wait_done(1000, bcyc);
      chk("multi_busy_cycles", bcyc, 4 * 129);
      chk("multi_edges", edges - e0, 128);
      chk("multi_chain", chain, words[3]);
      wb_read(2'd1, st(0, 1, 1, 0), "multi_status");
      wb_read(2'd3, words[2], "multi_readback");
      wb_xfer(1'b1, 2'd1, 32'h18);

      // Abort at bit 10 of the second of three words
      e0 = edges;
      for (int i = 0; i < 3; i++) push_word($urandom, 1);
      n = 0;
      while ((edges - e0) < 42 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_bit", edges - e0, 42);
      wb_xfer(1'b1, 2'd0, 32'h4);
      bit_q.delete();
      chk("abort_busy", 32'(busy), 0);
      chk("abort_prog_clk", 32'(pclk), 0);
      wb_read(2'd1, st(0, 0, 0, 0), "abort_status");
      repeat (20) @(negedge clk);
      chk("abort_no_more_edges", edges - e0, 42);

      // Interrupt
      wb_xfer(1'b1, 2'd0, 32'h2);
      push_word($urandom, 1);
      wait_done(400, bcyc);
      repeat (2) @(negedge clk);
      chk("irq_high", 32'(irq), 1);
      wb_read(2'd1, st(0, 0, 1, 0), "irq_status");
      wb_xfer(1'b1, 2'd1, 32'h8);
      chk("irq_low", 32'(irq), 0);
      wb_read(2'd0, 32'h2, "irq_ctrl");

      repeat (5) @(negedge clk);
      chk("reads_drained", exp_q.size(), 0);
      chk("bits_drained", bit_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpga_ccff_loader.md
# fpga_ccff_loader

Wishbone-slave bitstream programmer that drives the FPGA fabric configuration chain from the Caravel management SoC. Software pushes 32-bit bitstream words into a small FIFO. A shift engine serializes each word MSB-first onto `ccff_head_o`, generates `prog_clk_o`, and captures the chain output from `ccff_tail_i` for readback. It sits in `user_project_wrapper` in the `wbs_stb_can_i` address slot and feeds `fpga_core`'s `prog_clk`, `prog_reset` and `ccff_head` in place of GPIO-driven programming.

## Interface
- `CLK_DIV`, default 2: `prog_clk_o` half-period in `wb_clk_i` cycles; legal range ≥ 1.
- `FIFO_DEPTH`, default 4: number of bitstream words buffered; power of two, ≥ 2.

- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: reset; synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone strobe, cycle and write-enable.
- `wbs_sel_i` in 4: ignored; all accesses are full-word.
- `wbs_dat_i` in 32: write data.
- `wbs_adr_i` in 32: only bits [3:2] are decoded.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: read data, valid while `wbs_ack_o` is high, 0 otherwise.
- `prog_clk_o` out 1: configuration chain clock.
- `prog_reset_o` out 1: configuration chain reset.
- `ccff_head_o` out 1: serial configuration data into the chain.
- `ccff_tail_i` in 1: serial data out of the chain.
- `busy_o` out 1: shift engine is not in IDLE.
- `irq_o` out 1: done interrupt, level-sensitive.

## Operation
- **Register map** (adr[3:2]):
  - 0 CTRL, R/W:
    - bit0 `prog_reset`, reset value 1, drives `prog_reset_o` directly.
    - bit1 `irq_en`, reset value 0.
    - bit2 `abort`, write-1 pulse; always reads 0.
  - 1 STATUS:
    - bit0 busy, RO.
    - bit1 full, RO.
    - bit2 empty, RO.
    - bit3 done: sticky; cleared by writing 1 to it.
    - bit4 overflow: sticky; cleared by writing 1 to it.
    - [10:8] FIFO level, RO.
    - Other bits read 0.
  - 2 DATA, WO:
    - A write pushes `wbs_dat_i` into the FIFO.
    - A write when the FIFO is full is dropped and sets overflow.
    - A read returns 0.
  - 3 READBACK, RO: the 32-bit shift register of captured `ccff_tail_i` bits; newest bit is in bit0.
- **Wishbone handshake:**
  - When `stb & cyc & ~ack`, assert `wbs_ack_o` on the next cycle for exactly one cycle.
  - Write side effects and read data take effect in the ack cycle.
  - A strobe held high produces one ack per two cycles.
- **Shift FSM states:** IDLE, LOAD, LOW, HIGH.
  - IDLE → LOAD when the FIFO is not empty and `prog_reset` = 0.
  - LOAD (1 cycle):
    - Pop the FIFO head into the 32-bit shift register.
    - Set bitcnt to 0.
    - Go to LOW.
  - LOW (`CLK_DIV` cycles):
    - `prog_clk_o` = 0.
    - `ccff_head_o` = shreg[31] from the first LOW cycle onward.
    - On the last LOW cycle, shift `ccff_tail_i` into READBACK.
    - Then go to HIGH.
  - HIGH (`CLK_DIV` cycles):
    - `prog_clk_o` = 1; `ccff_head_o` is held.
    - On the last HIGH cycle, shift shreg left by 1 and increment bitcnt.
    - If bitcnt was 31 and the FIFO is not empty, go to LOAD.
    - If bitcnt was 31 and the FIFO is empty, go to IDLE and set done.
    - Otherwise go to LOW.
- **Abort, or a write setting `prog_reset` = 1, while not IDLE:**
  - The FSM goes to IDLE on the next cycle and `prog_clk_o` = 0.
  - The FIFO is flushed (level 0).
  - done is not set.
  - This is the only way a partial word is shifted.
- **Bitstream length:** software pads the bitstream to a multiple of 32 bits; the leading pad bits fall off the tail.
- **Simultaneous FIFO push and pop in one cycle:**
  - Both take effect and the level is unchanged.
  - Push-when-full with a pop in the same cycle is accepted.
- **Outputs:**
  - `busy_o` = (state != IDLE).
  - `irq_o` = done & `irq_en`, registered.
- **Reset values:**
  - `prog_clk_o` 0, `prog_reset_o` 1, `ccff_head_o` 0.
  - `wbs_ack_o` 0, `wbs_dat_o` 0.
  - `busy_o` 0, `irq_o` 0.
  - FIFO empty, READBACK 0, done 0, overflow 0.

## Timing
- `ccff_head_o` setup to the `prog_clk_o` rising edge: `CLK_DIV` cycles; hold: `CLK_DIV` cycles.
- Per word: 1 + 64·`CLK_DIV` cycles. The LOAD cycle between back-to-back words extends the LOW phase by one cycle.
- First rising edge of `prog_clk_o`: 1 + `CLK_DIV` cycles after LOAD entry.
- `ccff_tail_i` is sampled one cycle before each rising edge of `prog_clk_o`.
- All outputs are registered; there are no combinational paths from input to output.
- Wishbone latency: 1 cycle; no wait states.

## Test plan
- **Reset values:** assert `wb_rst_i` for 2 cycles → every output at its reset value; STATUS reads 0x0000_0004; CTRL reads 0x1.
- **Single word:**
  - Stimulus: `CLK_DIV` = 2; write CTRL = 0; write DATA = 0xA500_0001.
  - `busy_o` high for exactly 129 cycles, starting the cycle after the LOAD condition is met.
  - 32 rising edges of `prog_clk_o`.
  - `ccff_head_o` at the rising edges is 1,0,1,0,0,1,0,1, then 0×23, then 1.
  - Afterwards, done = 1.
- **Readback:**
  - Stimulus: drive `ccff_tail_i` from a model 32-bit chain preloaded with 0x1234_5678; shift one word.
  - READBACK reads 0x1234_5678.
  - The chain contents equal the written word.
- **FIFO depth and overflow:**
  - Stimulus: with `prog_reset` = 1, write DATA five times.
  - Level = 4, full = 1, overflow = 1.
  - Clear `prog_reset` → exactly 4 words (128 edges) are shifted, then done.
- **Abort:**
  - Stimulus: write CTRL abort at bit 10 of the second of three words.
  - Next cycle: IDLE, `prog_clk_o` = 0, FIFO level 0, done = 0.
- **Interrupt:**
  - Stimulus: `irq_en` = 1; one word completes → `irq_o` goes high.
  - Write 1 to STATUS bit3 → `irq_o` goes low one cycle after the ack.
